uart_tx_arbiter: RTL and testbench

Shares a single UART transmitter among NUM_REQ byte requesters. Requesters offer bytes on valid/ready handshakes; the arbiter grants them round-robin, drives the transmitter's start strobe and byte, waits for its done strobe, and enforces an inter-frame gap and a stuck-transmitter timeout. It sits between the command/stream sources and the UART_Tx instance, running on the system clock.

---
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with inter-frame gap and stuck-frame timeout
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                       i_clk_sys,
    input  logic                       i_rst_l,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*8-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_byte,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic [NUM_REQ-1:0]         o_done,
    output logic                       o_timeout
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  rr_q, rr_d, grant_q, grant_d, sel, cand;
    logic [7:0]     byte_q, byte_d, dsel;
    logic           start_q, start_d, busy_q, busy_d, timeout_q, timeout_d, found;
    logic [NUM_REQ-1:0] done_q, done_d;

    // first valid requester above the last grant, wrapping, plus its byte
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        dsel  = 8'h00;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(rr_q) + i) % NUM_REQ);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (sel == IW'(k)) dsel = i_req_data[8*k +: 8];
    end

    // next state, counter and registered output pulses; ready is the only combinational output
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        rr_d        = rr_q;
        grant_d     = grant_q;
        byte_d      = byte_q;
        start_d     = 1'b0;
        timeout_d   = 1'b0;
        done_d      = '0;
        o_req_ready = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    o_req_ready[sel] = 1'b1;
                    byte_d  = dsel;
                    grant_d = sel;
                    rr_d    = sel;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (i_tx_done) begin
                    done_d[grant_q] = 1'b1;
                    state_d = (GAP_CLKS > 0) ? GAP : IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CW'(TIMEOUT_CLKS - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            GAP: begin
                if (cnt_q >= CW'(GAP_CLKS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers; rr starts at the top so requester 0 wins first
    always_ff @(posedge i_clk_sys or negedge i_rst_l) begin
        if (!i_rst_l) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= IW'(NUM_REQ - 1);
            grant_q   <= '0;
            byte_q    <= 8'h00;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            byte_q    <= byte_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign o_tx_start = start_q;
    assign o_tx_byte  = byte_q;
    assign o_busy     = busy_q;
    assign o_grant_id = grant_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (4 requesters, 10-clock gap, 50-clock timeout)
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        i_rst_l;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;
    logic        i_tx_done;
    logic        o_busy;
    logic [1:0]  o_grant_id;
    logic [3:0]  o_done;
    logic        o_timeout;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  xfer = 4'b0;
    logic        final_chk = 1'b0;

    typedef struct {
        int kind;
        int data;
        int id;
        int dv;
        int cyc;
    } ev_t;
    ev_t q[$];

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(10), .TIMEOUT_CLKS(50)) dut (
        .i_clk_sys   (clk),
        .i_rst_l     (i_rst_l),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_tx_start  (o_tx_start),
        .o_tx_byte   (o_tx_byte),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id),
        .o_done      (o_done),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    // cycle stamp and record of handshakes completed at each edge
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        xfer <= i_rst_l ? (i_req_valid & o_req_ready) : 4'b0;
    end

    function automatic void push(int kind, int data, int id, int dv, int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.id   = id;
        e.dv   = dv;
        e.cyc  = c;
        q.push_back(e);
    endfunction

    task automatic cmp(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    // kind: 0 start, 1 done, 2 timeout
    task automatic chk_ev(input int kind, input int data, input int id, input int dv);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d expected none", cyc, kind);
        end else begin
            e = q.pop_front();
            cmp("event_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                cmp("tx_byte", data, e.data);
                cmp("grant_id", id, e.id);
                cmp("busy_at_start", int'(o_busy), 1);
            end
            if (kind == 1 && e.kind == 1) cmp("done_vec", dv, e.dv);
            if (e.cyc >= 0) cmp("event_cycle", cyc, e.cyc);
        end
    endtask

    // monitor: reset values while reset is low, otherwise scoreboard every output event
    always @(negedge clk) begin
        if (!i_rst_l) begin
            cmp("rst_tx_start", int'(o_tx_start), 0);
            cmp("rst_busy", int'(o_busy), 0);
            cmp("rst_done", int'(o_done), 0);
            cmp("rst_timeout", int'(o_timeout), 0);
            cmp("rst_tx_byte", int'(o_tx_byte), 0);
            cmp("rst_grant_id", int'(o_grant_id), 0);
        end else begin
            if (o_tx_start) chk_ev(0, int'(o_tx_byte), int'(o_grant_id), 0);
            if (|o_done) chk_ev(1, 0, 0, int'(o_done));
            if (o_timeout) chk_ev(2, 0, 0, 0);
        end
        if (final_chk) cmp("queue_drained", q.size(), 0);
    end

    task automatic step();
        @(negedge clk);
        i_req_valid = i_req_valid & ~xfer;
        i_tx_done   = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!o_tx_start && k < 300);
        if (!o_tx_start) begin
            $display("FAIL wait_start at cycle %0d: got no start expected start", cyc);
            $fatal(1, "no start strobe");
        end
    endtask

    task automatic pulse_done();
        step();
        i_tx_done = 1'b1;
    endtask

    initial begin
        int rd[4];
        int rid[4];
        int s;
        rd  = '{8'h11, 8'h22, 8'h33, 8'h44};
        rid = '{0, 1, 2, 0};
        i_rst_l = 1'b1;
        i_req_valid = 4'b0;
        i_req_data = 32'h0;
        i_tx_done = 1'b0;
        #1 i_rst_l = 1'b0;
        repeat (3) step();
        i_rst_l = 1'b1;
        step();

        // round robin from reset: 0,1,2 then requester 0's second byte
        i_req_data = 32'h0033_2211;
        i_req_valid = 4'b0111;
        push(0, rd[0], rid[0], 0, cyc + 1);
        for (int i = 0; i < 4; i++) begin
            wait_start();
            if (i == 0) begin
                i_req_data[7:0] = 8'h44;
                i_req_valid[0] = 1'b1;
            end
            pulse_done();
            push(1, 0, 0, 1 << rid[i], cyc + 1);
            if (i < 3) push(0, rd[i+1], rid[i+1], 0, cyc + 12);
        end
        repeat (12) step();

        // single byte; done pulses in GAP and IDLE are ignored
        i_req_data[7:0] = 8'hA5;
        i_req_valid = 4'b0001;
        push(0, 8'hA5, 0, 0, cyc + 1);
        wait_start();
        pulse_done();
        push(1, 0, 0, 4'b0001, cyc + 1);
        repeat (3) step();
        i_tx_done = 1'b1;
        repeat (12) step();
        i_tx_done = 1'b1;
        repeat (2) step();

        // timeout with no done, then the pending requester is served
        i_req_data[15:8] = 8'h5A;
        i_req_data[23:16] = 8'h77;
        i_req_valid = 4'b0110;
        push(0, 8'h5A, 1, 0, cyc + 1);
        wait_start();
        s = cyc;
        push(2, 0, 0, 0, s + 50);
        push(0, 8'h77, 2, 0, s + 51);
        wait_start();
        pulse_done();
        push(1, 0, 0, 4'b0100, cyc + 1);
        repeat (12) step();

        // done in the very cycle the timeout would fire
        i_req_data[31:24] = 8'hC3;
        i_req_valid = 4'b1000;
        push(0, 8'hC3, 3, 0, cyc + 1);
        wait_start();
        repeat (48) step();
        pulse_done();
        push(1, 0, 0, 4'b1000, cyc + 1);
        repeat (14) step();

        // asynchronous reset mid-frame; afterwards requester 1 beats 3
        i_req_data[23:16] = 8'h99;
        i_req_valid = 4'b0100;
        push(0, 8'h99, 2, 0, cyc + 1);
        wait_start();
        repeat (3) step();
        i_req_data[15:8] = 8'h10;
        i_req_data[31:24] = 8'h30;
        i_req_valid = 4'b1010;
        @(posedge clk);
        #2 i_rst_l = 1'b0;
        repeat (2) step();
        push(0, 8'h10, 1, 0, cyc + 1);
        i_rst_l = 1'b1;
        wait_start();
        pulse_done();
        push(1, 0, 0, 4'b0010, cyc + 1);
        push(0, 8'h30, 3, 0, cyc + 12);
        wait_start();
        pulse_done();
        push(1, 0, 0, 4'b1000, cyc + 1);
        repeat (12) step();

        final_chk = 1'b1;
        repeat (2) step();
        final_chk = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
